// File: rtl/hex_display_decoder.sv
// hex_display_decoder
//
// Receiving end of the multiplexed 4-digit seven-segment display bus. It
// watches the digit-select grid and samples each digit's segments once the
// select has been steady long enough. It assembles the samples into complete
// scans and publishes a 16-bit value (plus per-digit decimal points) only
// after ROUNDS consecutive identical, glyph-clean scans.
//
// Parameters
//   SETTLE  : cycles a digit select must stay steady before sampling (>=1)
//   ROUNDS  : consecutive identical complete scans needed to publish (>=1)
//   TIMEOUT : cycles without any digit sample before valid drops (>=1)
//
// Ports
//   Clk      in   system clock, rising edge
//   Reset    in   synchronous, active-low reset
//   hex_seg  in   [7:0] segments, active-low {dp,g,f,e,d,c,b,a}
//   hex_grid in   [3:0] digit select, active-low one-hot (bit 3 = value[15:12])
//   value    out  [15:0] last published display value
//   dp       out  [3:0] published decimal points (1 = lit)
//   valid    out  value is current (cleared by the idle timeout)
//   update   out  one-cycle pulse when a publish changes value/dp or revalidates
//   seg_err  out  one-cycle pulse after sampling a pattern that is not a hex glyph

module hex_display_decoder #(
    parameter int SETTLE  = 4,
    parameter int ROUNDS  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  hex_seg,
    input  logic [3:0]  hex_grid,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        valid,
    output logic        update,
    output logic        seg_err
);

    // Counter widths; a parameter of 1 still needs a 1-bit register.
    localparam int CNT_W   = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
    localparam int MATCH_W = (ROUNDS  > 1) ? $clog2(ROUNDS)  : 1;
    localparam int IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(ROUNDS - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } dwell_state_t;

    // Input register stage
    logic [7:0]         seg_q;
    logic [3:0]         grid_q;

    // Dwell FSM
    dwell_state_t       state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [3:0]         cur_grid_reg;

    // Scan assembly / matching
    logic [3:0]         seen_reg;
    logic               bad_reg;
    logic [MATCH_W-1:0] match_reg;
    logic [MATCH_W-1:0] match_next;
    logic [15:0]        prev_value_reg;
    logic [3:0]         prev_dp_reg;
    logic               prev_ok_reg;
    logic [IDLE_W-1:0]  idle_reg;
    logic [IDLE_W-1:0]  idle_next;

    // Output registers
    logic [15:0]        value_reg;
    logic [3:0]         dp_reg;
    logic               valid_reg;
    logic               update_reg;
    logic               seg_err_reg;

    // Combinational helpers
    logic               grid_legal;
    logic               grid_changed;
    logic               sample_ready;
    logic               sample_now;
    logic [4:0]         glyph;
    logic               glyph_ok;
    logic [3:0]         glyph_nib;
    logic               sample_dp;
    logic               scan_done;
    logic               scan_bad;
    logic               same_as_prev;
    logic [15:0]        scan_value;
    logic [3:0]         scan_dp;

    // Seven-segment pattern (gfedcba, active-low) to {legal, nibble}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        case (pat)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    // Exactly one select line low.
    always_comb begin
        grid_legal = 1'b0;
        case (grid_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: grid_legal = 1'b1;
            default:                            grid_legal = 1'b0;
        endcase
    end

    assign grid_changed = (grid_q != cur_grid_reg);

    // cnt counts the steady edges after the one that entered SETTLE, so the
    // sample lands on the edge where grid_q has been steady SETTLE cycles.
    // The >= form also covers SETTLE=1, which samples on the first check.
    assign sample_ready = (int'(cnt_reg) + 1 >= SETTLE - 1);
    assign sample_now   = (state_reg == ST_SETTLE) && grid_legal &&
                          !grid_changed && sample_ready;

    assign glyph     = decode_glyph(seg_q[6:0]);
    assign glyph_ok  = glyph[4];
    assign glyph_nib = glyph[3:0];
    assign sample_dp = ~seg_q[7];

    // Per-digit scan buffer. The assembled scan includes the sample being
    // taken this cycle so completion can be judged without an extra cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] nib_reg;
            logic       dpb_reg;
            logic       wr_en;

            assign wr_en = sample_now && !grid_q[gi];

            always_ff @(posedge Clk) begin
                if (wr_en) begin
                    nib_reg <= glyph_nib;
                    dpb_reg <= sample_dp;
                end
            end

            assign scan_value[4*gi +: 4] = wr_en ? glyph_nib : nib_reg;
            assign scan_dp[gi]           = wr_en ? sample_dp : dpb_reg;
        end
    endgenerate

    assign scan_done    = sample_now && ((seen_reg | ~grid_q) == 4'hF);
    assign scan_bad     = bad_reg || !glyph_ok;
    assign same_as_prev = prev_ok_reg && (scan_value == prev_value_reg) &&
                          (scan_dp == prev_dp_reg);

    always_comb begin
        match_next = '0;
        if (same_as_prev) begin
            match_next = (match_reg == MATCH_MAX) ? match_reg : match_reg + 1'b1;
        end
    end

    always_comb begin
        idle_next = idle_reg;
        if (idle_reg != IDLE_MAX) begin
            idle_next = idle_reg + 1'b1;
        end
    end

    // Input register stage and dwell FSM
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            seg_q        <= 8'hFF;
            grid_q       <= 4'hF;
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            cur_grid_reg <= 4'hF;
        end else begin
            seg_q  <= hex_seg;
            grid_q <= hex_grid;
            case (state_reg)
                ST_IDLE: begin
                    if (grid_legal) begin
                        state_reg    <= ST_SETTLE;
                        cnt_reg      <= '0;
                        cur_grid_reg <= grid_q;
                    end
                end
                ST_SETTLE: begin
                    if (!grid_legal) begin
                        state_reg <= ST_IDLE;
                    end else if (grid_changed) begin
                        cnt_reg      <= '0;
                        cur_grid_reg <= grid_q;
                    end else if (sample_ready) begin
                        state_reg <= ST_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!grid_legal) begin
                        state_reg <= ST_IDLE;
                    end else if (grid_changed) begin
                        state_reg    <= ST_SETTLE;
                        cnt_reg      <= '0;
                        cur_grid_reg <= grid_q;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Scan tracking, matching, publishing and timeout
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            seen_reg       <= '0;
            bad_reg        <= 1'b0;
            match_reg      <= '0;
            prev_value_reg <= '0;
            prev_dp_reg    <= '0;
            prev_ok_reg    <= 1'b0;
            idle_reg       <= '0;
            value_reg      <= '0;
            dp_reg         <= '0;
            valid_reg      <= 1'b0;
            update_reg     <= 1'b0;
            seg_err_reg    <= 1'b0;
        end else begin
            update_reg  <= 1'b0;
            seg_err_reg <= 1'b0;
            if (sample_now) begin
                idle_reg    <= '0;
                seg_err_reg <= !glyph_ok;
                if (scan_done) begin
                    seen_reg <= '0;
                    bad_reg  <= 1'b0;
                    if (scan_bad) begin
                        // A corrupted scan breaks the chain entirely; the
                        // next clean scan has nothing to match against.
                        match_reg   <= '0;
                        prev_ok_reg <= 1'b0;
                    end else begin
                        match_reg      <= match_next;
                        prev_value_reg <= scan_value;
                        prev_dp_reg    <= scan_dp;
                        prev_ok_reg    <= 1'b1;
                        if (match_next == MATCH_MAX) begin
                            value_reg  <= scan_value;
                            dp_reg     <= scan_dp;
                            valid_reg  <= 1'b1;
                            update_reg <= !valid_reg || (scan_value != value_reg) ||
                                          (scan_dp != dp_reg);
                        end
                    end
                end else begin
                    seen_reg <= seen_reg | ~grid_q;
                    if (!glyph_ok) begin
                        bad_reg <= 1'b1;
                    end
                end
            end else begin
                idle_reg <= idle_next;
                if (idle_next == IDLE_MAX) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    end

    assign value   = value_reg;
    assign dp      = dp_reg;
    assign valid   = valid_reg;
    assign update  = update_reg;
    assign seg_err = seg_err_reg;

endmodule

// File: tb/tb_hex_display_decoder.sv
// tb_hex_display_decoder
//
// Drives whole display scans (digits 3,2,1,0) onto the multiplexed bus, with
// optional glitch grids and too-short dwells between digits, and compares
// update/seg_err pulse counts and the published outputs after every scan
// against a scan-level reference model: a value is published when the last
// ROUNDS clean scans since reset or since a corrupted scan are identical.

module tb_hex_display_decoder;

    localparam int SETTLE  = 4;
    localparam int ROUNDS  = 2;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  hex_seg;
    logic [3:0]  hex_grid;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        valid;
    logic        update;
    logic        seg_err;

    always #5 clk = ~clk;

    hex_display_decoder #(
        .SETTLE  (SETTLE),
        .ROUNDS  (ROUNDS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .hex_seg  (hex_seg),
        .hex_grid (hex_grid),
        .value    (value),
        .dp       (dp),
        .valid    (valid),
        .update   (update),
        .seg_err  (seg_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int upd_total = 0;
    int err_total = 0;

    // Glyph table (gfedcba, active-low) indexed by nibble.
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [19:0] hist [$];
    logic [15:0] m_value = '0;
    logic [3:0]  m_dp    = '0;
    logic        m_valid = 1'b0;

    always @(negedge clk) begin
        if (update === 1'b1)  upd_total++;
        if (seg_err === 1'b1) err_total++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] bad_pattern();
        logic [6:0] p;
        bit         hit;
        do begin
            p   = 7'($urandom);
            hit = 1'b0;
            foreach (glyph_tab[i]) if (glyph_tab[i] == p) hit = 1'b1;
        end while (hit);
        return p;
    endfunction

    task automatic dwell(input logic [3:0] grid, input logic [7:0] seg, input int n);
        hex_grid = grid;
        hex_seg  = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scan-level model: any illegal glyph voids the history; otherwise
    // publish once the last ROUNDS clean scans are all identical.
    task automatic model_scan(input logic [15:0] v, input logic [3:0] d, input logic [3:0] badmask,
                              output int e_upd, output int e_err);
        logic [19:0] rec;
        bit          all_same;
        e_err = $countones(badmask);
        e_upd = 0;
        if (badmask != 4'b0) begin
            hist.delete();
            return;
        end
        rec = {d, v};
        hist.push_back(rec);
        if (hist.size() > ROUNDS) void'(hist.pop_front());
        if (hist.size() == ROUNDS) begin
            all_same = 1'b1;
            foreach (hist[i]) if (hist[i] != rec) all_same = 1'b0;
            if (all_same) begin
                if (!m_valid || rec != {m_dp, m_value}) e_upd = 1;
                m_value = v;
                m_dp    = d;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic run_scan(input string name, input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] badmask, input logic [6:0] bad_pat, input bit glitchy);
        int upd0, err0, e_upd, e_err;
        upd0 = upd_total;
        err0 = err_total;
        for (int k = 3; k >= 0; k--) begin
            logic [6:0] pat;
            logic [3:0] grid;
            pat  = badmask[k] ? bad_pat : glyph_tab[v[4*k +: 4]];
            grid = ~(4'b0001 << k);
            dwell(grid, {~d[k], pat}, $urandom_range(8, 20));
            if (glitchy) begin
                dwell(4'b1100, {1'b1, 7'h7F}, $urandom_range(1, 2));
                dwell(~(4'b0001 << ((k + 2) % 4)), {1'b1, 7'h7F}, 3);
                dwell(4'b1111, 8'hFF, $urandom_range(1, 3));
            end
        end
        model_scan(v, d, badmask, e_upd, e_err);
        $display("scan %-8s drive=%h dp=%b bad=%b glitch=%0d | value=%h dp=%b valid=%b upd=%0d err=%0d",
                 name, v, d, badmask, glitchy, value, dp, valid, upd_total - upd0, err_total - err0);
        check_val({name, " update count"}, upd_total - upd0, e_upd);
        check_val({name, " seg_err count"}, err_total - err0, e_err);
        check_val({name, " value"}, value, m_value);
        check_val({name, " dp"}, dp, m_dp);
        check_val({name, " valid"}, valid, m_valid);
    endtask

    task automatic check_zero_outputs(input string name);
        check_val({name, " value"}, value, 0);
        check_val({name, " dp"}, dp, 0);
        check_val({name, " valid"}, valid, 0);
        check_val({name, " update"}, update, 0);
        check_val({name, " seg_err"}, seg_err, 0);
    endtask

    initial begin
        logic [15:0] cur_v;
        logic [3:0]  cur_d;
        logic [3:0]  bm;
        int          r;

        rst_n    = 1'b0;
        hex_grid = 4'hF;
        hex_seg  = 8'hFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_zero_outputs("reset");
        rst_n = 1'b1;
        dwell(4'hF, 8'hFF, 2);

        // Clean display: publish after the 2nd identical scan only.
        for (int i = 0; i < 3; i++) run_scan("clean", 16'h3A7F, 4'b0000, 4'b0, 7'h7F, 1'b0);

        // New value held back until two scans agree.
        for (int i = 0; i < 2; i++) run_scan("change", 16'h0001, 4'b0000, 4'b0, 7'h7F, 1'b0);

        // Glitch grids and 3-cycle dwells must not sample anything.
        for (int i = 0; i < 2; i++) run_scan("glitch", 16'h0001, 4'b0000, 4'b0, 7'h7F, 1'b1);

        // Blank glyph on digit 1 voids the scan and the match history.
        run_scan("glyph", 16'h5C2E, 4'b0000, 4'b0, 7'h7F, 1'b0);
        run_scan("glyph", 16'h5C2E, 4'b0000, 4'b0010, 7'h7F, 1'b0);
        run_scan("glyph", 16'h5C2E, 4'b0000, 4'b0, 7'h7F, 1'b0);
        run_scan("glyph", 16'h5C2E, 4'b0000, 4'b0, 7'h7F, 1'b0);

        // Timeout: valid holds well before TIMEOUT idle cycles, drops after.
        dwell(4'hF, 8'hFF, 60);
        check_val("timeout early valid", valid, m_valid);
        dwell(4'hF, 8'hFF, 50);
        m_valid = 1'b0;
        check_val("timeout valid", valid, m_valid);
        check_val("timeout value hold", value, m_value);
        check_val("timeout dp hold", dp, m_dp);

        // Reset in the middle of a scan.
        dwell(4'b0111, {1'b1, glyph_tab[5]}, 12);
        dwell(4'b1011, {1'b1, glyph_tab[12]}, 2);
        rst_n    = 1'b0;
        hex_grid = 4'hF;
        hex_seg  = 8'hFF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero_outputs("midreset");
        hist.delete();
        m_value = '0;
        m_dp    = '0;
        m_valid = 1'b0;
        dwell(4'hF, 8'hFF, 3);
        for (int i = 0; i < 2; i++) run_scan("postrst", 16'h5C2E, 4'b0000, 4'b0, 7'h7F, 1'b0);

        // Decimal points, then a dp-only change on digit 1.
        for (int i = 0; i < 2; i++) run_scan("dp", 16'h1234, 4'b1001, 4'b0, 7'h7F, 1'b0);
        for (int i = 0; i < 2; i++) run_scan("dptoggle", 16'h1234, 4'b1011, 4'b0, 7'h7F, 1'b0);

        // Randomized scans.
        cur_v = 16'h1234;
        cur_d = 4'b1011;
        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                cur_v = 16'($urandom);
                cur_d = 4'($urandom);
            end else if (r == 2) begin
                cur_d[$urandom_range(0, 3)] ^= 1'b1;
            end
            bm = ($urandom_range(0, 6) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0;
            run_scan("rand", cur_v, cur_d, bm, bad_pattern(), ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
